div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 137 +++++++++++++
 tb/tb_div_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential 32-bit DIV/DIVU unit: restoring shift-subtract, one bit per cycle, IDLE/DIV/DONE FSM.
// Optional: define DIV_ZERO_FAST_EN to let a zero divisor skip the 32 iteration cycles.
module div_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        stall,
    output logic        done,
    output logic [63:0] divres,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic [31:0] quo_q, quo_d;
    logic [32:0] rem_q, rem_d;
    logic [63:0] res_q, res_d;

    logic [31:0] a_mag, b_mag_in;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] q_fix, r_fix;
    logic [63:0] result;

    // Magnitudes of the incoming operands; |0x80000000| still fits 32 unsigned bits.
    assign a_mag    = (signed_div && a[31]) ? (32'd0 - a) : a;
    assign b_mag_in = (signed_div && b[31]) ? (32'd0 - b) : b;

    // One restoring step: shift next dividend bit into a 33-bit partial remainder.
    assign rem_sh = {rem_q[31:0], quo_q[31]};
    assign rem_ge = (rem_sh >= {1'b0, b_mag_q});

    assign q_fix  = (sgn_q && (sa_q ^ sb_q)) ? (32'd0 - quo_q) : quo_q;
    assign r_fix  = (sgn_q && sa_q) ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    assign result = (b_mag_q == 32'd0) ? {a_raw_q, 32'hFFFF_FFFF} : {r_fix, q_fix};

    assign done      = (state_q == S_DONE) && !cancel;
    assign busy      = (state_q == S_DIV);
    assign stall     = start && !done && !cancel;
    assign divres    = done ? result : res_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_raw_d = a_raw_q;
        b_mag_d = b_mag_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        res_d   = done ? result : res_q;

        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    sgn_d   = signed_div;
                    sa_d    = signed_div && a[31];
                    sb_d    = signed_div && b[31];
                    a_raw_d = a;
                    b_mag_d = b_mag_in;
                    quo_d   = a_mag;
                    rem_d   = 33'd0;
                    cnt_d   = 5'd0;
`ifdef DIV_ZERO_FAST_EN
                    state_d = (b == 32'd0) ? S_DONE : S_DIV;
`else
                    state_d = S_DIV;
`endif
                end
            end
            S_DIV: begin
                rem_d = rem_ge ? (rem_sh - {1'b0, b_mag_q}) : rem_sh;
                quo_d = {quo_q[30:0], rem_ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush abandons whatever is in flight, including a pending result.
        if (cancel) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            sgn_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_raw_q <= 32'd0;
            b_mag_q <= 32'd0;
            quo_q   <= 32'd0;
            rem_q   <= 33'd0;
            res_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_raw_q <= a_raw_d;
            b_mag_q <= b_mag_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized operations
// checked cycle by cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_div_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        stall, done, busy;
    logic [63:0] divres;
    logic [1:0]  dbg_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res = 64'd0;

    always #5 clk = ~clk;

    div_seq dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .stall      (stall),
        .done       (done),
        .divres     (divres),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain 64-bit integer division; C-style truncation gives the
    // remainder the dividend's sign, and -2^31 / -1 wraps to 0x80000000.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] av, input logic [31:0] bv);
        longint na, nb, q, r;
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        if (sd) begin
            na = longint'($signed(av));
            nb = longint'($signed(bv));
        end else begin
            na = longint'({32'd0, av});
            nb = longint'({32'd0, bv});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int latency(input logic [31:0] bv);
`ifdef DIV_ZERO_FAST_EN
        if (bv == 32'd0) return 1;
`endif
        return 33;
    endfunction

    // kind: 0 = run to completion, 1 = cancel at cycle abort_at, 2 = reset at cycle abort_at.
    task automatic run_op(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                          input int abort_at, input int kind);
        int          lat;
        logic        st;
        logic [63:0] exp;
        lat = latency(bv);
        exp_q.push_back(model(sd, av, bv));
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            st = (k == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            start  = st;
            cancel = 1'b0;
            if (k == 0) begin
                signed_div = sd; a = av; b = bv;
            end else begin
                signed_div = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
            end
            if (k == abort_at && kind == 1) begin
                cancel = 1'b1;
                #1;
                check("cancel_stall", stall, 0);
                check("cancel_done", done, 0);
                check("cancel_divres", divres, last_res);
                void'(exp_q.pop_back());
                @(posedge clk); #1;
                start = 1'b0; cancel = 1'b0;
                #1;
                check("cancel_idle_busy", busy, 0);
                check("cancel_idle_done", done, 0);
                return;
            end
            if (k == abort_at && kind == 2) begin
                resetn = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_divres", divres, 0);
                check("rst_stall", stall, st);
                void'(exp_q.pop_back());
                last_res = 64'd0;
                return;
            end
            @(negedge clk);
            check("done", done, k == lat);
            check("stall", stall, st && (k != lat));
            check("busy", busy, (k > 0) && (k < lat));
            if (k == lat) begin
                exp = exp_q.pop_front();
                check("divres", divres, exp);
                last_res = exp;
            end else begin
                check("divres_hold", divres, last_res);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0; cancel = 1'b0;
            @(negedge clk);
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_stall", stall, 0);
            check("idle_divres", divres, last_res);
        end
    endtask

    function automatic logic [31:0] pick_b();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(2, 300));
            4: return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_a();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'd0;
            2: return 32'($urandom_range(0, 1000));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset state, including stall following start while held in reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_divres", divres, 0);
        check("reset_stall", stall, 0);
        start = 1'b1; a = 32'd9; b = 32'd3;
        @(posedge clk); @(negedge clk);
        check("reset_stall_start", stall, 1);
        check("reset_busy_start", busy, 0);
        start = 1'b0;
        resetn = 1'b1;

        // Directed cases.
        run_op(1'b0, 32'd7, 32'd2, -1, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
        run_op(1'b0, 32'h1234_5678, 32'd0, -1, 0);
        run_op(1'b1, 32'h1234_5678, 32'd0, -1, 0);
        idle(2);

        // Cancel mid-operation, then a fresh start two cycles later.
        run_op(1'b0, 32'd1000, 32'd3, 10, 1);
        run_op(1'b0, 32'd5, 32'd5, -1, 0);

        // Back-to-back DIVU.
        run_op(1'b0, 32'd100, 32'd7, -1, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, -1, 0);

        // Cancel together with start in IDLE: nothing starts.
        @(posedge clk); #1;
        start = 1'b1; cancel = 1'b1; a = 32'd50; b = 32'd5; signed_div = 1'b0;
        #1;
        check("cancel_start_stall", stall, 0);
        @(negedge clk);
        check("cancel_start_done", done, 0);
        idle(36);

        // Reset mid-DIV: no done pulse afterwards.
        run_op(1'b1, 32'hDEAD_BEEF, 32'd17, 20, 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold_busy", busy, 0);
        start = 1'b0;
        resetn = 1'b1;
        idle(40);

        // First edge after reset release takes a start.
        run_op(1'b1, 32'hFFFF_FF00, 32'hFFFF_FFF0, -1, 0);

        // Randomized operations with occasional gaps and aborts.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                run_op(1'($urandom_range(0, 1)), pick_a(), pick_b(), $urandom_range(1, 30), 1);
            end else begin
                run_op(1'($urandom_range(0, 1)), pick_a(), pick_b(), -1, 0);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
